// File: rtl/op_trans_pkg.sv
// rtl/op_trans_pkg.sv - shared widths and id-width helper for the op_trans datapath
package op_trans_pkg;

    localparam int OP_N_REQ     = 4;
    localparam int OP_IN_WIDTH  = 42;
    localparam int OP_OUT_WIDTH = 19;

    // Requester id width: clog2 of the requester count, never below one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, scans from ptr upward with wrap
module rr_pick
    import op_trans_pkg::*;
#(
    parameter int N_REQ    = OP_N_REQ,
    parameter int ID_WIDTH = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [N_REQ-1:0]    grant,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/shift_rr_arbiter.sv
// rtl/shift_rr_arbiter.sv - round-robin shared truncate datapath; SHIFT_ARB_ROUND_EN enables round-half-up
module shift_rr_arbiter
    import op_trans_pkg::*;
#(
    parameter int N_REQ        = OP_N_REQ,
    parameter int INPUT_WIDTH  = OP_IN_WIDTH,
    parameter int OUTPUT_WIDTH = OP_OUT_WIDTH,
    parameter int ID_WIDTH     = id_width(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             in_valid,
    output logic [N_REQ-1:0]             in_ready,
    input  logic [N_REQ*INPUT_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUTPUT_WIDTH-1:0]      out_data,
    output logic [ID_WIDTH-1:0]          out_id
);

    localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;

    logic [ID_WIDTH-1:0]     ptr;
    logic [ID_WIDTH-1:0]     ptr_next;
    logic [N_REQ-1:0]        grant;
    logic [ID_WIDTH-1:0]     idx;
    logic                    any;
    logic                    load;
    logic [OUTPUT_WIDTH-1:0] field;
    logic [OUTPUT_WIDTH-1:0] result;
    int                      base;

    rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    assign load     = ~out_valid | out_ready;
    // Held off during reset so no requester believes its word was taken.
    assign in_ready = (load & ~rst) ? grant : '0;
    assign ptr_next = (int'(idx) == N_REQ - 1) ? '0 : idx + ID_WIDTH'(1);

    always_comb begin
        base  = int'(idx) * INPUT_WIDTH;
        field = in_data[base + SHIFT +: OUTPUT_WIDTH];
    end

`ifdef SHIFT_ARB_ROUND_EN
    logic                  round_bit;
    logic [OUTPUT_WIDTH:0] sum;

    always_comb begin
        round_bit = in_data[base + SHIFT - 1];
        sum       = {1'b0, field} + {{OUTPUT_WIDTH{1'b0}}, round_bit};
        // Carry out means the field was all-ones: saturate instead of wrapping.
        result    = sum[OUTPUT_WIDTH] ? '1 : sum[OUTPUT_WIDTH-1:0];
    end
`else
    assign result = field;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_id    <= idx;
                ptr       <= ptr_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// tb/tb_shift_rr_arbiter.sv - randomized and directed bench against a behavioural arbiter model
module tb_shift_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready;
    logic [167:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [18:0]  out_data;
    logic [1:0]   out_id;

    int vectors = 0;
    int miscompares = 0;

    int          m_ptr = 0;
    bit          m_valid = 0;
    logic [18:0] m_data = '0;
    logic [1:0]  m_id = '0;

    shift_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] f_ref(input logic [41:0] w);
        longint v;
        v = longint'(w) / 64'd8388608;
`ifdef SHIFT_ARB_ROUND_EN
        if (w[22]) v = v + 1;
        if (v > 524287) v = 524287;
`endif
        return v[18:0];
    endfunction

    function automatic int pick();
        for (int k = 0; k < 4; k++) begin
            if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int g;
        r = '0;
        g = pick();
        if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [41:0] word(input int i);
        return in_data[i*42 +: 42];
    endfunction

    task automatic set_word(input int i, input logic [41:0] w);
        in_data[i*42 +: 42] = w;
    endtask

    task automatic rand_words();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) begin
            r = {$urandom(), $urandom()};
            set_word(i, r[41:0]);
        end
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic cycle();
        int g;
        bit ld;
        logic [41:0] w;
        g  = pick();
        ld = !m_valid || out_ready;
        w  = (g >= 0) ? word(g) : '0;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_data = '0; m_id = '0; m_ptr = 0;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1; m_data = f_ref(w); m_id = g[1:0]; m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; rand_words();
        for (int c = 0; c < 2; c++) begin
            cycle();
            vectors++;
            if (in_ready !== 4'h0) begin
                miscompares++; $display("FAIL reset_in_ready got %h want 0", in_ready);
            end
            vectors++;
            if (out_valid !== 1'b0 || out_data !== 19'h0 || out_id !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_out got v=%b d=%h id=%0d want 0/0/0", out_valid, out_data, out_id);
            end
        end
        rst = 1'b0; #1;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++; $display("FAIL reset_first_grant got %b want 0001", in_ready);
        end
        cycle();
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            miscompares++; $display("FAIL reset_first_id got v=%b id=%0d want 1/0", out_valid, out_id);
        end
    endtask

    task automatic test_single();
        in_valid = 4'b0010; out_ready = 1'b1; set_word(1, 42'h3FF_FFFF_FFFF); #1;
        vectors++;
        if (in_ready !== 4'b0010) begin
            miscompares++; $display("FAIL single_ready got %b want 0010", in_ready);
        end
        cycle();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 19'h7FFFF || out_id !== 2'd1) begin
            miscompares++;
            $display("FAIL single_out got v=%b d=%h id=%0d want 1/7ffff/1", out_valid, out_data, out_id);
        end
    endtask

    task automatic test_fairness();
        rst = 1'b1; cycle(); rst = 1'b0;
        in_valid = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_words(); #1;
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++; $display("FAIL fair_ready[%0d] got %b want %b", c, in_ready, exp_ready());
            end
            cycle();
            vectors++;
            if (out_valid !== 1'b1 || out_id !== 2'(c % 4) || out_data !== m_data) begin
                miscompares++;
                $display("FAIL fair_out[%0d] got v=%b id=%0d d=%h want 1/%0d/%h", c, out_valid, out_id, out_data, c % 4, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] hd;
        logic [1:0]  hid;
        hd = out_data; hid = out_id;
        out_ready = 1'b0; in_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            rand_words(); #1;
            vectors++;
            if (in_ready !== 4'h0) begin
                miscompares++; $display("FAIL bp_ready[%0d] got %b want 0", c, in_ready);
            end
            cycle();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== hd || out_id !== hid) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d want 1/%h/%0d", c, out_valid, out_data, out_id, hd, hid);
            end
        end
        out_ready = 1'b1; #1;
        cycle();
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'((int'(hid) + 1) % 4) || out_data !== m_data) begin
            miscompares++;
            $display("FAIL bp_release got id=%0d d=%h want %0d/%h", out_id, out_data, (int'(hid) + 1) % 4, m_data);
        end
    endtask

    task automatic test_rounding();
        logic [18:0] exp_r;
`ifdef SHIFT_ARB_ROUND_EN
        exp_r = 19'h00002;
`else
        exp_r = 19'h00001;
`endif
        rst = 1'b1; cycle(); rst = 1'b0;
        out_ready = 1'b1; in_valid = 4'b0001; set_word(0, 42'h000_00C0_0000);
        cycle();
        vectors++;
        if (out_data !== exp_r || out_id !== 2'd0) begin
            miscompares++; $display("FAIL round_half got %h want %h", out_data, exp_r);
        end
        set_word(0, 42'h3FF_FFFF_FFFF);
        cycle();
        vectors++;
        if (out_data !== 19'h7FFFF) begin
            miscompares++; $display("FAIL round_sat got %h want 7ffff", out_data);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 4'b0100; set_word(2, 42'h155_5555_5555); out_ready = 1'b0;
        cycle();
        in_valid = 4'h0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_drop got out_valid=%b want 0", out_valid);
        end
        in_valid = 4'hF; out_ready = 1'b1; set_word(0, 42'h0AA_AAAA_AAAA); #1;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++; $display("FAIL mid_ptr got %b want 0001", in_ready);
        end
        cycle();
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== f_ref(42'h0AA_AAAA_AAAA)) begin
            miscompares++;
            $display("FAIL mid_next got id=%0d d=%h want 0/%h", out_id, out_data, f_ref(42'h0AA_AAAA_AAAA));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            rand_words(); #1;
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++; $display("FAIL rand_ready[%0d] got %b want %b", c, in_ready, exp_ready());
            end
            cycle();
            vectors++;
            if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_id !== m_id))) begin
                miscompares++;
                $display("FAIL rand_out[%0d] got v=%b d=%h id=%0d want %b/%h/%0d", c, out_valid, out_data, out_id, m_valid, m_data, m_id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_rounding();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
